// File: rtl/logic_unit_pkg.sv
// Shared definitions for the sequential bit-slice logic unit:
// operation encodings and the controller state type.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NOTA = 3'b100;
    localparam logic [2:0] OP_ANDN = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// Purely combinational SLICE-wide bitwise operator. The sequential top
// feeds it one slice of the latched operands per RUN cycle.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [2:0]       op,
    output logic [SLICE-1:0] y
);

    // Select the bitwise function; every encoding is defined, so no bit
    // depends on any other bit position.
    always_comb begin
        y = a;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_NOTA: y = ~a;
            OP_ANDN: y = a & ~b;
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Sequential logic unit: processes WIDTH-bit operands SLICE bits per cycle,
// LSB slice first, then publishes the whole result on Rz.
// Optional feature: define LU_ZERO_FLAG_EN to add the registered 'zero' flag.
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    output logic [WIDTH-1:0] Rz,
    output logic             busy,
    output logic             done
`ifdef LU_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    sliceCnt_q, sliceCnt_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [2:0]       opSel_q, opSel_d;
    logic [WIDTH-1:0] accum_q, accum_d;
    logic [WIDTH-1:0] rz_q, rz_d;
`ifdef LU_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic [IW-1:0]    bitBase;
    logic [SLICE-1:0] sliceY;

    // Bit offset of the slice being worked on this cycle.
    assign bitBase = IW'(int'(sliceCnt_q) * SLICE);

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (opA_q[bitBase +: SLICE]),
        .b  (opB_q[bitBase +: SLICE]),
        .op (opSel_q),
        .y  (sliceY)
    );

    // Controller next-state: accept requests in IDLE/DONE, step through the
    // slices in RUN and hand the assembled word to Rz on the final slice.
    always_comb begin
        state_d    = state_q;
        sliceCnt_d = sliceCnt_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        opSel_d    = opSel_q;
        accum_d    = accum_q;
        rz_d       = rz_q;
`ifdef LU_ZERO_FLAG_EN
        zero_d     = zero_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    opA_d      = Ra;
                    opB_d      = Rb;
                    opSel_d    = op;
                    sliceCnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                accum_d[bitBase +: SLICE] = sliceY;
                if (sliceCnt_q == LAST_SLICE) begin
                    rz_d    = accum_d;
`ifdef LU_ZERO_FLAG_EN
                    zero_d  = (accum_d == '0);
`endif
                    state_d = ST_DONE;
                end else begin
                    sliceCnt_d = sliceCnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; clr low aborts everything immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= ST_IDLE;
            sliceCnt_q <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            opSel_q    <= '0;
            accum_q    <= '0;
            rz_q       <= '0;
        end else begin
            state_q    <= state_d;
            sliceCnt_q <= sliceCnt_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            opSel_q    <= opSel_d;
            accum_q    <= accum_d;
            rz_q       <= rz_d;
        end
    end

`ifdef LU_ZERO_FLAG_EN
    // Zero flag tracks Rz and is loaded on the same edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`endif

    assign Rz   = rz_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed testbench for logic_unit_seq: default 32/8 instance plus
// SLICE=32 and SLICE=1 instances. Zero flag checked when LU_ZERO_FLAG_EN is set.
module tb_logic_unit_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start, startW, startB;
    logic [2:0]  op;
    logic [31:0] Ra, Rb;
    logic [31:0] Rz, RzW, RzB;
    logic        busy, busyW, busyB;
    logic        done, doneW, doneB;
`ifdef LU_ZERO_FLAG_EN
    logic        zero, zeroW, zeroB;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] expAll [8] = '{32'hABCD1234, 32'hFFFFFFFF, 32'h5432EDCB, 32'h00000000,
                                32'h00000000, 32'h5432EDCB, 32'hABCD1234, 32'hFFFFFFFF};

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .Ra(Ra), .Rb(Rb),
        .Rz(Rz), .busy(busy), .done(done)
`ifdef LU_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(32)) dutW (
        .clk(clk), .clr(clr), .start(startW), .op(op), .Ra(Ra), .Rb(Rb),
        .Rz(RzW), .busy(busyW), .done(doneW)
`ifdef LU_ZERO_FLAG_EN
        , .zero(zeroW)
`endif
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(1)) dutB (
        .clk(clk), .clr(clr), .start(startB), .op(op), .Ra(Ra), .Rb(Rb),
        .Rz(RzB), .busy(busyB), .done(doneB)
`ifdef LU_ZERO_FLAG_EN
        , .zero(zeroB)
`endif
    );

    // Reset state, then release clr on a falling edge.
    task automatic test_reset();
        clr = 1'b0; start = 1'b0; startW = 1'b0; startB = 1'b0;
        op = 3'b000; Ra = '0; Rb = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (Rz !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rz got %h want %h", Rz, 32'h0); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
`ifdef LU_ZERO_FLAG_EN
        vectors++;
        if (zero !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_zero got %b want 1", zero); end
`endif
        clr = 1'b1;
    endtask

    // OR with start in the first cycle after reset release; checks busy/done timing.
    task automatic test_or();
        op = 3'b001; Ra = 32'hAAAAAAAA; Rb = 32'h55555555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL or_busy_cycle%0d got busy=%b done=%b want busy=1 done=0", i, busy, done);
            end
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL or_done got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        vectors++;
        if (Rz !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL or_rz got %h want FFFFFFFF", Rz); end
`ifdef LU_ZERO_FLAG_EN
        vectors++;
        if (zero !== 1'b0) begin miscompares++; $display("[TB] FAIL or_zero got %b want 0", zero); end
`endif
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL or_done_pulse got %b want 0", done); end
    endtask

    // Every op on FFFFFFFF / ABCD1234, with latency check.
    task automatic test_all_ops();
        int cyc;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i); Ra = 32'hFFFFFFFF; Rb = 32'hABCD1234; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 1;
            while (done !== 1'b1 && cyc < 12) begin
                @(negedge clk);
                cyc++;
            end
            vectors++;
            if (cyc != 5) begin miscompares++; $display("[TB] FAIL ops_latency op%0d got %0d want 5", i, cyc); end
            vectors++;
            if (Rz !== expAll[i]) begin miscompares++; $display("[TB] FAIL ops_rz op%0d got %h want %h", i, Rz, expAll[i]); end
`ifdef LU_ZERO_FLAG_EN
            vectors++;
            if (zero !== (expAll[i] == 32'h0)) begin
                miscompares++;
                $display("[TB] FAIL ops_zero op%0d got %b want %b", i, zero, (expAll[i] == 32'h0));
            end
`endif
            @(negedge clk);
        end
    endtask

    // Inputs and start toggled while busy must not disturb the operation.
    task automatic test_operand_change();
        int doneCount;
        op = 3'b001; Ra = 32'h00000037; Rb = 32'h00000073; start = 1'b1;
        @(negedge clk);
        Ra = 32'hFFFFFFFF; Rb = 32'hFFFFFFFF; op = 3'b111; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || Rz !== 32'h00000077) begin
            miscompares++;
            $display("[TB] FAIL change_rz got done=%b rz=%h want done=1 rz=00000077", done, Rz);
        end
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) doneCount++;
        end
        vectors++;
        if (doneCount != 0) begin miscompares++; $display("[TB] FAIL change_extra_op got %0d active cycles want 0", doneCount); end
    endtask

    // Second request accepted in the DONE cycle of the first.
    task automatic test_back_to_back();
        int cyc;
        op = 3'b001; Ra = 32'hAAAAAAAA; Rb = 32'h55555555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || Rz !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("[TB] FAIL b2b_first got done=%b rz=%h want done=1 rz=FFFFFFFF", done, Rz);
        end
        op = 3'b000; Ra = 32'h0000FFFF; Rb = 32'hFFFF0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || Rz !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("[TB] FAIL b2b_hold got busy=%b rz=%h want busy=1 rz=FFFFFFFF", busy, Rz);
        end
        cyc = 1;
        while (done !== 1'b1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != 5) begin miscompares++; $display("[TB] FAIL b2b_latency got %0d want 5", cyc); end
        vectors++;
        if (Rz !== 32'h0) begin miscompares++; $display("[TB] FAIL b2b_rz got %h want 00000000", Rz); end
`ifdef LU_ZERO_FLAG_EN
        vectors++;
        if (zero !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_zero got %b want 1", zero); end
`endif
        @(negedge clk);
    endtask

    // clr during RUN aborts immediately; no done afterwards.
    task automatic test_reset_mid_run();
        int cyc;
        int activeCount;
        op = 3'b111; Ra = 32'hDEADBEEF; Rb = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (Rz !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL abort_setup got %h want DEADBEEF", Rz); end
        @(negedge clk);
        op = 3'b010; Ra = 32'h12345678; Rb = 32'h0F0F0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        #1;
        vectors++;
        if (Rz !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_state got rz=%h busy=%b done=%b want 0/0/0", Rz, busy, done);
        end
        @(negedge clk);
        clr = 1'b1;
        activeCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) activeCount++;
        end
        vectors++;
        if (activeCount != 0) begin miscompares++; $display("[TB] FAIL abort_no_done got %0d active cycles want 0", activeCount); end
    endtask

    // SLICE=32 and SLICE=1 instances run all ops side by side.
    task automatic test_sweep();
        int doneWAt, doneBAt, busyWCnt, busyBCnt;
        logic [31:0] rzWCap, rzBCap;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i); Ra = 32'hFFFFFFFF; Rb = 32'hABCD1234;
            startW = 1'b1; startB = 1'b1;
            @(negedge clk);
            startW = 1'b0; startB = 1'b0;
            doneWAt = 0; doneBAt = 0; busyWCnt = 0; busyBCnt = 0;
            rzWCap = '0; rzBCap = '0;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                if (busyW === 1'b1) busyWCnt++;
                if (busyB === 1'b1) busyBCnt++;
                if (doneW === 1'b1 && doneWAt == 0) begin doneWAt = cyc; rzWCap = RzW; end
                if (doneB === 1'b1 && doneBAt == 0) begin doneBAt = cyc; rzBCap = RzB; end
                @(negedge clk);
            end
            vectors++;
            if (busyWCnt != 1 || doneWAt != 2) begin
                miscompares++;
                $display("[TB] FAIL sweep32_timing op%0d got busy=%0d doneAt=%0d want busy=1 doneAt=2", i, busyWCnt, doneWAt);
            end
            vectors++;
            if (rzWCap !== expAll[i]) begin miscompares++; $display("[TB] FAIL sweep32_rz op%0d got %h want %h", i, rzWCap, expAll[i]); end
            vectors++;
            if (busyBCnt != 32 || doneBAt != 33) begin
                miscompares++;
                $display("[TB] FAIL sweep1_timing op%0d got busy=%0d doneAt=%0d want busy=32 doneAt=33", i, busyBCnt, doneBAt);
            end
            vectors++;
            if (rzBCap !== expAll[i]) begin miscompares++; $display("[TB] FAIL sweep1_rz op%0d got %h want %h", i, rzBCap, expAll[i]); end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_or();
        test_all_ops();
        test_operand_change();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
